// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch with one outstanding imem request, a single
//                skid entry and the IF/ID register feeding decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic [31:0] inst_code_o
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_kill;
  logic        r_skid_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic        r_slot_valid;
  logic [31:0] r_slot_pc;
  logic [31:0] r_slot_inst;

  logic        w_consume;
  logic        w_slot_free;
  logic [31:0] w_target;

  assign w_consume   = r_slot_valid && !stall_i;
  assign w_slot_free = !r_slot_valid || w_consume;
  assign w_target    = redirect_pc_i & ~32'h0000_0003;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_REQ;
    else          r_state <= w_state_next;
  end

  // Redirect only alters the transition where a response or the skid is involved.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_REQ:  if (imem_ready_i) w_state_next = S_WAIT;
      S_WAIT: if (imem_rvalid_i)
                w_state_next = (r_kill || redirect_i || w_slot_free) ? S_REQ : S_HOLD;
      S_HOLD: if (redirect_i || w_consume) w_state_next = S_REQ;
      default: w_state_next = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_o    = reset_n && (r_state == S_REQ);
    imem_addr_o   = r_pc;
    if_valid_o    = r_slot_valid;
    if_pc_o       = r_slot_pc;
    if_pc_plus4_o = r_slot_pc + 32'd4;
    inst_code_o   = r_slot_inst;
  end

  // The slot instruction is kept at NOP_INST whenever the slot is empty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_kill       <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= 32'd0;
      r_skid_inst  <= NOP_INST;
      r_slot_valid <= 1'b0;
      r_slot_pc    <= 32'd0;
      r_slot_inst  <= NOP_INST;
    end else if (redirect_i) begin
      r_pc         <= w_target;
      r_slot_valid <= 1'b0;
      r_slot_inst  <= NOP_INST;
      r_skid_valid <= 1'b0;
      r_kill       <= ((r_state == S_REQ) && imem_ready_i) ||
                      ((r_state == S_WAIT) && !imem_rvalid_i);
    end else begin
      if (w_consume) begin
        r_slot_valid <= 1'b0;
        r_slot_inst  <= NOP_INST;
      end
      case (r_state)
        S_REQ: if (imem_ready_i) r_req_pc <= r_pc;
        S_WAIT: if (imem_rvalid_i) begin
          if (r_kill) begin
            r_kill <= 1'b0;
          end else if (w_slot_free) begin
            r_slot_valid <= 1'b1;
            r_slot_pc    <= r_req_pc;
            r_slot_inst  <= imem_rdata_i;
            r_pc         <= r_pc + 32'd4;
          end else begin
            r_skid_valid <= 1'b1;
            r_skid_pc    <= r_req_pc;
            r_skid_inst  <= imem_rdata_i;
            r_pc         <= r_pc + 32'd4;
          end
        end
        S_HOLD: if (w_consume) begin
          r_slot_valid <= 1'b1;
          r_slot_pc    <= r_skid_pc;
          r_slot_inst  <= r_skid_inst;
          r_skid_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Scoreboard bench for fetch_stage with a latency-programmable
//                instruction memory returning addr|0x13.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i  = 32'd0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic [31:0] inst_code_o;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_pc_plus4_o (if_pc_plus4_o),
    .inst_code_o   (inst_code_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    exp_pc_q.push_back(pc);
    exp_inst_q.push_back(inst);
  endtask

  // Memory model: accepts at the negedge view, answers mem_lat cycles later.
  logic        acc = 1'b0;
  logic [31:0] acc_addr = 32'd0;
  logic [31:0] paddr = 32'd0;
  int          cnt = 0;
  int          mem_lat = 1;

  always @(negedge clk) begin
    acc      = reset_n && imem_req_o && imem_ready_i;
    acc_addr = imem_addr_o;
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid_i = 1'b0;
    if (!reset_n) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = paddr | 32'h13;
        end
      end
      if (acc) begin
        paddr = acc_addr;
        if (mem_lat <= 1) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = paddr | 32'h13;
        end else begin
          cnt = mem_lat - 1;
        end
      end
    end
  end

  // Monitor: every instruction decode takes must match the scoreboard head.
  always @(negedge clk) begin
    if (reset_n) begin
      if (if_valid_o && !stall_i) begin
        if (exp_pc_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h expected none", if_pc_o);
        end else begin
          automatic logic [31:0] e_pc   = exp_pc_q.pop_front();
          automatic logic [31:0] e_inst = exp_inst_q.pop_front();
          chk("sb_pc", if_pc_o, e_pc);
          chk("sb_inst", inst_code_o, e_inst);
          chk("sb_pc_plus4", if_pc_plus4_o, e_pc + 32'd4);
        end
      end else if (!if_valid_o) begin
        chk("nop_when_empty", inst_code_o, 32'h0000_0013);
      end
    end
  end

  initial begin
    logic found;
    reset_n       = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    imem_ready_i  = 1'b1;
    push(32'hFFFF_FFFC, 32'hFFFF_FFFF);
    push(32'h0000_0000, 32'h0000_0013);
    push(32'h0000_0004, 32'h0000_0017);
    push(32'h0000_0008, 32'h0000_001B);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_pc_plus4", if_pc_plus4_o, 32'd4);
    chk("rst_inst", inst_code_o, 32'h13);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);

    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("lat_valid", {31'd0, if_valid_o}, 32'd1);
    chk("lat_pc", if_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", if_pc_plus4_o, 32'd0);

    // Stall with a response landing in the skid.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if_valid_o && if_pc_o == 32'h4) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_pc4", {31'd0, found}, 32'd1);
    stall_i = 1'b1;
    tick();
    tick();
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    chk("hold_pc", if_pc_o, 32'h4);
    tick();
    tick();
    chk("hold_req_late", {31'd0, imem_req_o}, 32'd0);
    tick();
    stall_i = 1'b0;
    tick();
    chk("skid_pc8", if_pc_o, 32'h8);
    chk("skid_valid", {31'd0, if_valid_o}, 32'd1);
    chk("after_skid_addr", imem_addr_o, 32'hC);
    mem_lat = 4;

    // Redirect in WAIT; the late response must be dropped.
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    tick();
    redirect_i = 1'b0;
    chk("kill_valid", {31'd0, if_valid_o}, 32'd0);
    chk("kill_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    tick();
    chk("kill_req_rvalid", {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("redir_req", {31'd0, imem_req_o}, 32'd1);
    chk("redir_addr", imem_addr_o, 32'h100);
    chk("redir_still_empty", {31'd0, if_valid_o}, 32'd0);
    mem_lat = 1;
    tick();
    tick();
    chk("redir_slot_pc", if_pc_o, 32'h100);
    chk("redir_slot_inst", inst_code_o, 32'h113);
    stall_i = 1'b1;
    push(32'h0000_0200, 32'h0000_0213);

    // Redirect while stalled with a full skid.
    tick();
    tick();
    chk("full_hold_req", {31'd0, imem_req_o}, 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    tick();
    chk("flush_valid", {31'd0, if_valid_o}, 32'd0);
    chk("flush_inst", inst_code_o, 32'h13);
    chk("flush_req", {31'd0, imem_req_o}, 32'd1);
    chk("flush_addr", imem_addr_o, 32'h200);
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    tick();
    tick();
    chk("target_pc", if_pc_o, 32'h200);
    mem_lat = 3;

    // Reset in WAIT.
    tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("mid_rst_pc", if_pc_o, 32'd0);
    chk("mid_rst_pc_plus4", if_pc_plus4_o, 32'd4);
    chk("mid_rst_inst", inst_code_o, 32'h13);
    chk("mid_rst_req", {31'd0, imem_req_o}, 32'd0);
    mem_lat = 1;
    push(32'hFFFF_FFFC, 32'hFFFF_FFFF);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rerst_req", {31'd0, imem_req_o}, 32'd1);
    chk("rerst_addr", imem_addr_o, 32'hFFFF_FFFC);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if_valid_o && if_pc_o == 32'h0) begin
        found = 1'b1;
        break;
      end
    end
    stall_i = 1'b1;
    chk("wrap_to_zero", {31'd0, found}, 32'd1);
    chk("wrap_inst", inst_code_o, 32'h13);
    repeat (3) tick();
    chk("sb_empty", exp_pc_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the RISC-V core. It holds the PC and issues word fetches to instruction memory through a request/response handshake, with at most one request outstanding. It presents each returned instruction, with its PC, to the decode stage, where `inst_code_o` drives the immediate generator and the control decoder. It also handles decode back-pressure (stall), control-flow redirects from EX, and discarding of in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `NOP_INST`, default 32'h0000_0013: instruction word presented when the output slot is empty or flushed (`addi x0,x0,0`).

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `stall_i` in 1: decode cannot accept; hold the IF/ID contents.
- `redirect_i` in 1: branch/jump taken; flush and refetch.
- `redirect_pc_i` in 32: target PC; bits [1:0] are ignored (forced 0).
- `imem_req_o` out 1: fetch request valid.
- `imem_addr_o` out 32: fetch address (word aligned).
- `imem_ready_i` in 1: memory accepts the request this cycle.
- `imem_rvalid_i` in 1: response valid.
- `imem_rdata_i` in 32: response instruction word.
- `if_valid_o` out 1: IF/ID slot holds a live instruction.
- `if_pc_o` out 32: PC of the instruction in the slot.
- `if_pc_plus4_o` out 32: `if_pc_o + 4`, modulo 2^32.
- `inst_code_o` out 32: instruction word; equals `NOP_INST` whenever `if_valid_o` = 0.

## Operation
- Registers:
  - `pc`: next fetch address.
  - FSM state.
  - `kill`: discard the pending response.
  - Skid entry: `skid_valid`, `skid_pc`, `skid_inst`.
  - Output slot: valid, pc, inst.
- Slot consume condition: `if_valid_o && !stall_i`. "Slot free" means `!if_valid_o || consume`.
- FSM states:
  - **REQ**:
    - Drives `imem_req_o`=1 and `imem_addr_o`=`pc`.
    - On `imem_ready_i`, go to WAIT and latch the request PC.
  - **WAIT**:
    - Drives `imem_req_o`=0 and waits for `imem_rvalid_i`.
    - On response with `kill`=1: drop the data, clear `kill`, go to REQ.
    - On response with the slot free: load the slot with (request PC, `imem_rdata_i`), set `pc += 4`, go to REQ.
    - On response with the slot not free: write the skid entry, set `pc += 4`, go to HOLD.
  - **HOLD**:
    - Drives `imem_req_o`=0.
    - On consume, move the skid entry into the slot, clear `skid_valid`, go to REQ.
- Redirect has priority over everything, including `stall_i`. In the cycle `redirect_i`=1:
  - Set `pc <= {redirect_pc_i[31:2],2'b00}`.
  - Clear the slot valid bit and load the slot instruction with `NOP_INST`; clear `skid_valid`.
  - State REQ without handshake → stay in REQ. The new PC is issued the next cycle.
  - State REQ with `imem_ready_i`=1 → the stale request was accepted: go to WAIT with `kill`=1.
  - State WAIT without `imem_rvalid_i` → stay in WAIT, set `kill`=1.
  - State WAIT with `imem_rvalid_i` → drop the response, go to REQ.
  - State HOLD → go to REQ.
- Stall with no redirect: slot, skid and `pc` hold. A response arriving in WAIT is captured in the skid; it is never lost.
- PC arithmetic is 32-bit and wraps (32'hFFFF_FFFC + 4 = 0). No misalignment check on fetched data.

## Timing
- Reset (`reset_n`=0 at a clock edge) gives:
  - state REQ, `pc`=`RESET_PC`, `kill`=0, `skid_valid`=0.
  - `if_valid_o`=0, `if_pc_o`=0, `inst_code_o`=`NOP_INST`.
- Reset values of the remaining outputs:
  - `if_pc_plus4_o`=4.
  - `imem_req_o`=0 while `reset_n`=0. It asserts in the first cycle after release.
- `imem_req_o` and `imem_addr_o` are decoded from registered state; there is no combinational path from the response inputs.
- Latency with `imem_ready_i` tied to 1 and a 1-cycle memory (rvalid the cycle after accept):
  - Request at cycle N, response at N+1, slot valid at N+2.
  - Steady-state throughput is 1 instruction per 2 cycles.
- Reset asserted mid-transaction: the state returns to REQ. Any response that arrives later is ignored because the block is not in WAIT; memory must be reset together with this block.
- Redirect takes effect at the edge where it is sampled. The first fetch of the target is requested in the cycle after a redirect taken from REQ, WAIT-with-response or HOLD. From WAIT without a response, the request follows the arrival of the killed response.

## Test plan
- Reset then straight-line fetch with memory returning `addr|0x13` and 1-cycle latency, `stall_i`=0 → slot shows pc 0, 4, 8, … every 2 cycles, with `if_pc_plus4_o` = pc+4.
- `stall_i`=1 for 5 cycles while a response arrives → slot holds pc 4. The response for pc 8 goes into the skid, no request issues during HOLD, and pc 8 appears one cycle after the stall drops.
- `redirect_i`=1 with `redirect_pc_i`=0x103 in WAIT, response arriving 3 cycles later → that response is discarded. The next request address is 0x100 and the slot stays NOP (`if_valid_o`=0) until the 0x100 word returns.
- Redirect coincident with `stall_i`=1 and a full skid → slot and skid are flushed, `inst_code_o`=0x00000013, and the next request is to the target.
- `RESET_PC`=32'hFFFF_FFFC → fetches 0xFFFFFFFC then 0x00000000.
- `reset_n` pulled low while in WAIT → all outputs return to reset values on the next edge, and `imem_req_o` is back to 1 with address `RESET_PC` one cycle after release.
